// File: rtl/noise_pkg.sv
// Shared definitions for the LFSR noise generator: tap mode encoding and the
// SPI configuration frame layout [enable][mode][div][seed], MSB first.
package noise_pkg;

   typedef enum logic {
      MODE_LONG  = 1'b0,
      MODE_SHORT = 1'b1
   } mode_e;

   localparam int unsigned ENABLE_W = 1;
   localparam int unsigned MODE_W   = 1;
   // Short mode only watches the low 7 bits for lock-up (period 127).
   localparam int unsigned SHORT_N  = 7;

   function automatic int unsigned frame_w(input int unsigned div_w, input int unsigned lfsr_w);
      return ENABLE_W + MODE_W + div_w + lfsr_w;
   endfunction

   function automatic int unsigned seed_lsb();
      return 0;
   endfunction

   function automatic int unsigned div_lsb(input int unsigned lfsr_w);
      return lfsr_w;
   endfunction

   function automatic int unsigned mode_bit(input int unsigned div_w, input int unsigned lfsr_w);
      return lfsr_w + div_w;
   endfunction

   function automatic int unsigned enable_bit(input int unsigned div_w,
                                              input int unsigned lfsr_w);
      return lfsr_w + div_w + MODE_W;
   endfunction

endpackage

// File: rtl/spi_cfg_rx.sv
// SPI configuration receiver: synchronises the 3-wire SPI pins into clk_i,
// shifts in one frame per chip-select window and strobes commit or error.
module spi_cfg_rx
   import noise_pkg::*;
#(
   parameter int unsigned FRAME_W = 42
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               spi_clock_i,
   input  logic               spi_data_i,
   input  logic               spi_cs_i,
   output logic [FRAME_W-1:0] frame_o,
   output logic               commit_o,
   output logic               cfg_ok_o,
   output logic               frame_err_o
);

   localparam int unsigned      CNT_W    = $clog2(FRAME_W + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
   localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

   logic [2:0]         sclk_q;
   logic [1:0]         sdat_q;
   logic [2:0]         scs_q;
   logic [FRAME_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cfg_ok_q, cfg_ok_d;
   logic               frame_err_q, frame_err_d;
   logic               sclk_rise, cs_fall, cs_rise, cs_low;

   // Two stages synchronise, the third stage is only for edge detection.
   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign cs_fall   = ~scs_q[1] & scs_q[2];
   assign cs_rise   = scs_q[1] & ~scs_q[2];
   assign cs_low    = ~scs_q[1];

   always_comb begin
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      cfg_ok_d    = 1'b0;
      frame_err_d = 1'b0;
      if (cs_fall) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (cs_rise) begin
         if (cnt_q == CNT_FULL) begin
            cfg_ok_d = 1'b1;
         end else begin
            frame_err_d = 1'b1;
         end
      end else if (cs_low && sclk_rise) begin
         shift_d = {shift_q[FRAME_W-2:0], sdat_q[1]};
         if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sclk_q      <= '0;
         sdat_q      <= '0;
         scs_q       <= '1;
         shift_q     <= '0;
         cnt_q       <= '0;
         cfg_ok_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sclk_q      <= {sclk_q[1:0], spi_clock_i};
         sdat_q      <= {sdat_q[0], spi_data_i};
         scs_q       <= {scs_q[1:0], spi_cs_i};
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         cfg_ok_q    <= cfg_ok_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Commit is combinational so the config lands on the same edge as cfg_ok.
   assign commit_o    = cfg_ok_d;
   assign frame_o     = shift_q;
   assign cfg_ok_o    = cfg_ok_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: rtl/noise_gen_lfsr.sv
// Fibonacci LFSR noise voice with programmable tick divider, long/short tap
// modes, lock-up recovery and SPI runtime configuration.
module noise_gen_lfsr
   import noise_pkg::*;
#(
   parameter int unsigned LFSR_W    = 23,
   parameter int unsigned TAP_A     = 22,
   parameter int unsigned TAP_B     = 17,
   parameter int unsigned SHORT_A   = 6,
   parameter int unsigned SHORT_B   = 5,
   parameter int unsigned DIV_W     = 17,
   parameter int unsigned SEED      = 111,
   parameter int unsigned DIV_RESET = 13000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              spi_clock,
   input  logic              spi_data,
   input  logic              spi_cs,
   output logic              noise_signal,
   output logic [LFSR_W-1:0] noise_word,
   output logic              cfg_ok,
   output logic              frame_err
);

   localparam int unsigned FRAME_W  = frame_w(DIV_W, LFSR_W);
   localparam int unsigned SEED_LSB = seed_lsb();
   localparam int unsigned DIV_LSB  = div_lsb(LFSR_W);
   localparam int unsigned MODE_POS = mode_bit(DIV_W, LFSR_W);
   localparam int unsigned EN_POS   = enable_bit(DIV_W, LFSR_W);

   logic [1:0]         rst_sync_q;
   logic               rst_n;
   logic [FRAME_W-1:0] frame;
   logic               commit;

   logic               en_q, en_d;
   mode_e              mode_q, mode_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic               sig_q, sig_d;
   logic               tick, fb, locked;

   // Reset asserts asynchronously and releases on a clock edge.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end
   assign rst_n = rst_sync_q[1];

   spi_cfg_rx #(
      .FRAME_W (FRAME_W)
   ) u_spi_cfg_rx (
      .clk_i       (sys_clk),
      .rst_ni      (rst_n),
      .spi_clock_i (spi_clock),
      .spi_data_i  (spi_data),
      .spi_cs_i    (spi_cs),
      .frame_o     (frame),
      .commit_o    (commit),
      .cfg_ok_o    (cfg_ok),
      .frame_err_o (frame_err)
   );

   assign tick = en_q && (cnt_q == div_q);

   always_comb begin
      if (mode_q == MODE_SHORT) begin
         fb     = lfsr_q[SHORT_A] ^ lfsr_q[SHORT_B];
         locked = (lfsr_q[SHORT_N-1:0] == '0);
      end else begin
         fb     = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
         locked = (lfsr_q == '0);
      end
   end

   always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      div_d  = div_q;
      cnt_d  = cnt_q;
      lfsr_d = lfsr_q;
      sig_d  = sig_q;
      if (commit) begin
         // A tick landing on the commit edge is dropped.
         en_d   = frame[EN_POS];
         mode_d = mode_e'(frame[MODE_POS]);
         div_d  = frame[DIV_LSB +: DIV_W];
         lfsr_d = frame[SEED_LSB +: LFSR_W];
         cnt_d  = '0;
      end else if (!en_q) begin
         cnt_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         if (locked) begin
            lfsr_d = LFSR_W'(SEED);
         end else begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
            sig_d  = fb;
         end
      end else begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b1;
         mode_q <= MODE_LONG;
         div_q  <= DIV_W'(DIV_RESET);
         cnt_q  <= '0;
         lfsr_q <= LFSR_W'(SEED);
         sig_q  <= 1'b0;
      end else begin
         en_q   <= en_d;
         mode_q <= mode_d;
         div_q  <= div_d;
         cnt_q  <= cnt_d;
         lfsr_q <= lfsr_d;
         sig_q  <= sig_d;
      end
   end

   assign noise_word   = lfsr_q;
   assign noise_signal = sig_q;

endmodule

// File: tb/tb_noise_gen_lfsr.sv
// Scoreboard bench for noise_gen_lfsr: expected LFSR states are queued as
// stimulus is issued; a negedge monitor pops one per observed output change.
module tb_noise_gen_lfsr;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n, spi_clock, spi_data, spi_cs;
   logic        noise_signal, cfg_ok, frame_err;
   logic [22:0] noise_word;

   noise_gen_lfsr #(
      .DIV_RESET (3)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .spi_clock    (spi_clock),
      .spi_data     (spi_data),
      .spi_cs       (spi_cs),
      .noise_signal (noise_signal),
      .noise_word   (noise_word),
      .cfg_ok       (cfg_ok),
      .frame_err    (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [22:0] word;
      logic        sig;
      int          gap;
   } exp_t;

   exp_t        exp_q[$];
   int          n_vec = 0, n_fail = 0, n_ok = 0, n_err = 0, since = 0;
   logic        chk_on = 1'b0, pred_on = 1'b0, last_sig = 1'b0;
   logic [22:0] prev_word;
   logic        prev_sig;
   // Reference model state, advanced by the predictor
   logic [22:0] m_lfsr;
   logic        m_sig, m_mode, m_en, m_skip;
   int          m_div;
   // Pending commit expectation
   logic        pend_valid = 1'b0, pend_en, pend_mode;
   logic [16:0] pend_div;
   logic [22:0] pend_seed;

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   // Predictor: keeps a few expected tick results queued ahead of the DUT.
   always @(posedge sys_clk) begin
      #2;
      if (pred_on && m_en) begin
         while (exp_q.size() < 3) begin
            logic fb, zero;
            exp_t e;
            if (m_mode) begin
               fb   = m_lfsr[6] ^ m_lfsr[5];
               zero = (m_lfsr[6:0] == 7'd0);
            end else begin
               fb   = m_lfsr[22] ^ m_lfsr[17];
               zero = (m_lfsr == 23'd0);
            end
            if (zero) begin
               m_lfsr = 23'd111;
            end else begin
               m_lfsr = {m_lfsr[21:0], fb};
               m_sig  = fb;
            end
            e.word = m_lfsr;
            e.sig  = m_sig;
            e.gap  = m_skip ? 0 : m_div + 1;
            m_skip = 1'b0;
            exp_q.push_back(e);
         end
      end
   end

   // Monitor
   always @(negedge sys_clk) begin
      since++;
      if (frame_err) n_err++;
      if (cfg_ok) begin
         n_ok++;
         n_vec++;
         if (!pend_valid) begin
            n_fail++;
            $display("FAIL unexpected_cfg_ok: got cfg_ok=1, want 0");
         end else if (noise_word !== pend_seed || noise_signal !== last_sig) begin
            n_fail++;
            $display("FAIL commit: got word=%0d sig=%0b, want word=%0d sig=%0b",
                     noise_word, noise_signal, pend_seed, last_sig);
         end
         if (pend_valid) begin
            exp_q.delete();
            m_lfsr = pend_seed;
            m_mode = pend_mode;
            m_en   = pend_en;
            m_div  = int'(pend_div);
            m_sig  = last_sig;
            m_skip = 1'b0;
         end
         pend_valid = 1'b0;
         since      = 0;
      end else if (chk_on && (noise_word !== prev_word || noise_signal !== prev_sig)) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change: got word=%0d sig=%0b, want no change",
                     noise_word, noise_signal);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            last_sig = e.sig;
            if (noise_word !== e.word || noise_signal !== e.sig ||
                (e.gap != 0 && since != e.gap)) begin
               n_fail++;
               $display("FAIL tick: got word=%0d sig=%0b gap=%0d, want word=%0d sig=%0b gap=%0d",
                        noise_word, noise_signal, since, e.word, e.sig, e.gap);
            end
         end
         since = 0;
      end
      prev_word = noise_word;
      prev_sig  = noise_signal;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [63:0] mk(input logic en, input logic mode, input logic [16:0] div,
                                      input logic [22:0] seed);
      return {22'd0, en, mode, div, seed};
   endfunction

   task automatic set_pend(input logic en, input logic mode, input logic [16:0] div,
                           input logic [22:0] seed);
      pend_en    = en;
      pend_mode  = mode;
      pend_div   = div;
      pend_seed  = seed;
      pend_valid = 1'b1;
   endtask

   task automatic spi_bits(input int n, input logic [63:0] v);
      for (int i = n - 1; i >= 0; i--) begin
         spi_data = v[i];
         cyc(4);
         spi_clock = 1'b1;
         cyc(4);
         spi_clock = 1'b0;
      end
   endtask

   task automatic finish_frame(input string name, input logic want_ok);
      int ok0, err0;
      ok0  = n_ok;
      err0 = n_err;
      cyc(4);
      spi_cs = 1'b1;
      for (int t = 0; t < 30 && n_ok == ok0 && n_err == err0; t++) cyc(1);
      cyc(4);
      pend_valid = 1'b0;
      check({name, "_cfg_ok"}, n_ok - ok0, want_ok ? 1 : 0);
      check({name, "_frame_err"}, n_err - err0, want_ok ? 0 : 1);
   endtask

   task automatic send(input string name, input int n, input logic [63:0] v,
                       input logic want_ok);
      spi_cs = 1'b0;
      cyc(4);
      spi_bits(n, v);
      finish_frame(name, want_ok);
   endtask

   // Hand-computed: seed 111 shifted with fb=0 for 11 ticks, then fb=1.
   int unsigned hand_w[12] = '{222, 444, 888, 1776, 3552, 7104, 14208, 28416, 56832,
                               113664, 227328, 454657};
   logic [6:0]  rec[128];

   initial begin
      sys_rst_n = 1'b0;
      spi_clock = 1'b0;
      spi_data  = 1'b0;
      spi_cs    = 1'b1;
      cyc(3);
      check("reset_word", int'(noise_word), 111);
      check("reset_sig", int'(noise_signal), 0);
      check("reset_pulses", int'({cfg_ok, frame_err}), 0);
      for (int k = 0; k < 12; k++) begin
         exp_t e;
         e.word = hand_w[k];
         e.sig  = (k == 11);
         e.gap  = (k == 0) ? 0 : 4;
         exp_q.push_back(e);
      end
      m_lfsr  = 23'd454657;
      m_sig   = 1'b1;
      m_mode  = 1'b0;
      m_en    = 1'b1;
      m_div   = 3;
      m_skip  = 1'b0;
      last_sig = 1'b0;
      chk_on  = 1'b1;
      pred_on = 1'b1;
      sys_rst_n = 1'b1;
      cyc(100);

      // Short mode, tick every cycle, seed 1
      set_pend(1'b1, 1'b1, 17'd0, 23'd1);
      send("short", 42, mk(1'b1, 1'b1, 17'd0, 23'd1), 1'b1);
      for (int i = 0; i < 128; i++) begin
         rec[i] = noise_word[6:0];
         cyc(1);
      end
      begin
         int zeros, early;
         zeros = 0;
         early = 0;
         for (int i = 0; i < 128; i++) if (rec[i] == 7'd0) zeros++;
         for (int i = 1; i < 127; i++) if (rec[i] == rec[0]) early++;
         check("short_period127", int'(rec[127]), int'(rec[0]));
         check("short_no_zero", zeros, 0);
         check("short_no_early_repeat", early, 0);
      end
      cyc(20);

      // Zero seed, long mode: first tick reloads 111
      set_pend(1'b1, 1'b0, 17'd0, 23'd0);
      send("zero_seed", 42, mk(1'b1, 1'b0, 17'd0, 23'd0), 1'b1);
      cyc(50);

      // Wrong-length frames are discarded
      send("len41", 41, mk(1'b1, 1'b1, 17'd5, 23'h55), 1'b0);
      cyc(30);
      send("len43", 43, mk(1'b0, 1'b1, 17'd9, 23'h7) | (64'd1 << 42), 1'b0);
      cyc(30);

      // Disable freezes outputs
      set_pend(1'b0, 1'b0, 17'd0, 23'h2AAAAA);
      send("disable", 42, mk(1'b0, 1'b0, 17'd0, 23'h2AAAAA), 1'b1);
      cyc(1000);
      check("frozen_word", int'(noise_word), int'(m_lfsr));
      check("frozen_sig", int'(noise_signal), int'(m_sig));
      set_pend(1'b1, 1'b0, 17'd2, 23'd1);
      send("resume_div2", 42, mk(1'b1, 1'b0, 17'd2, 23'd1), 1'b1);
      cyc(60);

      // Reset after 20 bits of a frame
      spi_cs = 1'b0;
      cyc(4);
      spi_bits(20, mk(1'b1, 1'b0, 17'd1, 23'd12345) >> 22);
      sys_rst_n = 1'b0;
      exp_q.delete();
      begin
         exp_t e;
         e.word = 23'd111;
         e.sig  = 1'b0;
         e.gap  = 0;
         exp_q.push_back(e);
      end
      m_lfsr = 23'd111;
      m_sig  = 1'b0;
      m_mode = 1'b0;
      m_en   = 1'b1;
      m_div  = 3;
      m_skip = 1'b1;
      #1;
      check("midreset_word", int'(noise_word), 111);
      check("midreset_sig", int'(noise_signal), 0);
      cyc(5);
      sys_rst_n = 1'b1;
      spi_bits(22, mk(1'b1, 1'b0, 17'd1, 23'd12345));
      finish_frame("after_reset", 1'b0);
      set_pend(1'b1, 1'b0, 17'd1, 23'd12345);
      send("final", 42, mk(1'b1, 1'b0, 17'd1, 23'd12345), 1'b1);
      cyc(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
